// File: rtl/ir_fetch_unit.sv
// Multi-beat instruction fetch: assembles BEATS memory words (LSW first) into ir_out.
// Latency BEATS+1 cycles with no wait states; mem_ready low stalls READ indefinitely.
module ir_fetch_unit #(
  parameter int          DW       = 8,
  parameter int          AW       = 8,
  parameter int          BEATS    = 2,
  parameter logic [AW-1:0] PC_RESET = '0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_fetch_req,
  input  logic                i_pc_load,
  input  logic [AW-1:0]       i_pc_load_val,
  input  logic                i_flush,
  input  logic [DW-1:0]       i_mem_rdata,
  input  logic                i_mem_ready,
  output logic [AW-1:0]       o_mem_addr,
  output logic                o_mem_cs,
  output logic                o_mem_wr,
  output logic [BEATS*DW-1:0] o_ir_out,
  output logic                o_ir_valid,
  output logic                o_fetch_busy,
  output logic                o_fetch_done,
  output logic [AW-1:0]       o_pc_out
);

  localparam int IW = BEATS * DW;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_pc;
  logic [2:0]      r_beat;
  logic [IW-1:0]   r_ir;
  logic            r_ir_valid;
  logic            r_done;
  logic            w_last;

  assign w_last = (r_beat == 3'(BEATS - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_pc       <= PC_RESET;
      r_beat     <= '0;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_pc_load) begin
            r_pc <= i_pc_load_val;
          end else if (i_fetch_req) begin
            r_state    <= S_READ;
            r_beat     <= '0;
            r_ir_valid <= 1'b0;
          end
        end
        S_READ: begin
          // Flush wins over a completing beat; consumed beats keep their PC advance.
          if (i_flush) begin
            r_state    <= S_IDLE;
            r_ir_valid <= 1'b0;
          end else if (i_mem_ready) begin
            r_ir[int'(r_beat)*DW +: DW] <= i_mem_rdata;
            r_pc   <= r_pc + 1'b1;
            r_beat <= r_beat + 3'd1;
            if (w_last) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          if (i_flush) begin
            r_ir_valid <= 1'b0;
          end else begin
            r_ir_valid <= 1'b1;
            r_done     <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_addr   = r_pc;
  assign o_pc_out     = r_pc;
  assign o_mem_cs     = (r_state == S_READ);
  assign o_mem_wr     = 1'b0;
  assign o_fetch_busy = (r_state != S_IDLE);
  assign o_ir_out     = r_ir;
  assign o_ir_valid   = r_ir_valid;
  assign o_fetch_done = r_done;

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Scoreboard bench for ir_fetch_unit: default 8/8/2 instance plus a 16/12/3 instance.
module tb_ir_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] ir;
    logic [15:0] pc;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // default instance
  logic        fetch_req0 = 0, pc_load0 = 0, flush0 = 0;
  logic [7:0]  pc_load_val0 = 0;
  logic [7:0]  mem0 [256];
  logic [7:0]  mem_addr0, pc0, rdata0;
  logic [15:0] ir0;
  logic        mem_cs0, mem_wr0, ir_valid0, busy0, done0, ready0;
  int          wait_n = 0;
  int          wcnt = 0;

  assign ready0 = (wcnt == wait_n);
  assign rdata0 = mem0[mem_addr0];

  always @(posedge clk or posedge rst)
    if (rst) wcnt <= 0;
    else if (mem_cs0 && !ready0) wcnt <= wcnt + 1;
    else wcnt <= 0;

  ir_fetch_unit dut0 (
    .i_clk(clk), .i_rst(rst), .i_fetch_req(fetch_req0), .i_pc_load(pc_load0),
    .i_pc_load_val(pc_load_val0), .i_flush(flush0), .i_mem_rdata(rdata0),
    .i_mem_ready(ready0), .o_mem_addr(mem_addr0), .o_mem_cs(mem_cs0), .o_mem_wr(mem_wr0),
    .o_ir_out(ir0), .o_ir_valid(ir_valid0), .o_fetch_busy(busy0),
    .o_fetch_done(done0), .o_pc_out(pc0)
  );

  // wide instance, always-ready memory
  logic        fetch_req1 = 0;
  logic [15:0] mem1 [16];
  logic [11:0] mem_addr1, pc1;
  logic [15:0] rdata1;
  logic [47:0] ir1;
  logic        mem_cs1, mem_wr1, ir_valid1, busy1, done1;

  assign rdata1 = mem1[mem_addr1[3:0]];

  ir_fetch_unit #(.DW(16), .AW(12), .BEATS(3)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_fetch_req(fetch_req1), .i_pc_load(1'b0),
    .i_pc_load_val(12'h0), .i_flush(1'b0), .i_mem_rdata(rdata1),
    .i_mem_ready(1'b1), .o_mem_addr(mem_addr1), .o_mem_cs(mem_cs1), .o_mem_wr(mem_wr1),
    .o_ir_out(ir1), .o_ir_valid(ir_valid1), .o_fetch_busy(busy1),
    .o_fetch_done(done1), .o_pc_out(pc1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitors: pop expected response whenever fetch_done pulses
  logic [7:0] prev_addr0 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (mem_cs0 && wcnt != 0) check("addr_stable0", 64'(mem_addr0), 64'(prev_addr0));
      prev_addr0 = mem_addr0;
      if (done0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done0 actual=1 required=0 at cycle %0d", cyc);
        end else begin
          e = q0.pop_front();
          check("ir0", 64'(ir0), e.ir);
          check("pc0", 64'(pc0), 64'(e.pc));
          check("valid0", 64'(ir_valid0), 64'd1);
          check("latency0", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done1 actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = q1.pop_front();
        check("ir1", 64'(ir1), e.ir);
        check("pc1", 64'(pc1), 64'(e.pc));
        check("valid1", 64'(ir_valid1), 64'd1);
        check("latency1", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // called at posedge+1; request is sampled on the following edge
  task automatic fetch0(input logic [15:0] ir, input logic [7:0] pc, input int lat);
    exp_t e;
    e.ir = 64'(ir); e.pc = 16'(pc); e.cyc = cyc + 1 + lat;
    q0.push_back(e);
    fetch_req0 = 1; @(posedge clk); #1 fetch_req0 = 0;
  endtask

  task automatic fetch1(input logic [47:0] ir, input logic [11:0] pc, input int lat);
    exp_t e;
    e.ir = 64'(ir); e.pc = 16'(pc); e.cyc = cyc + 1 + lat;
    q1.push_back(e);
    fetch_req1 = 1; @(posedge clk); #1 fetch_req1 = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
      @(posedge clk); n++;
    end
    #1;
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=%0d required=0 pending", name, q0.size() + q1.size());
      q0.delete(); q1.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"},    64'(pc0), 64'h0);
    check({tag, "_ir"},    64'(ir0), 64'h0);
    check({tag, "_valid"}, 64'(ir_valid0), 64'h0);
    check({tag, "_done"},  64'(done0), 64'h0);
    check({tag, "_busy"},  64'(busy0), 64'h0);
    check({tag, "_cs"},    64'(mem_cs0), 64'h0);
    check({tag, "_wr"},    64'(mem_wr0), 64'h0);
  endtask

  initial begin
    mem0[0] = 8'h34; mem0[1] = 8'h12; mem0[2] = 8'hCD; mem0[3] = 8'hAB;
    mem0[4] = 8'h5A; mem0[5] = 8'hA5; mem0[255] = 8'h78;
    for (int i = 0; i < 16; i++) mem1[i] = 16'h1111 * 16'(i + 1);

    #1 check_reset_outputs("reset");
    check("reset_pc1", 64'(pc1), 64'h0);
    check("reset_ir1", 64'(ir1), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    // basic two-beat fetch, zero wait states
    fetch0(16'h1234, 8'h02, 3);
    drain("basic");

    // two wait states per beat
    wait_n = 2;
    fetch0(16'hABCD, 8'h04, 7);
    drain("waits");
    wait_n = 0;

    // pc_load beats fetch_req in the same cycle; then fetch wraps through 0xFF
    pc_load0 = 1; pc_load_val0 = 8'hFF; fetch_req0 = 1;
    @(posedge clk); #1 pc_load0 = 0; fetch_req0 = 0;
    check("load_pc", 64'(pc0), 64'hFF);
    check("load_busy", 64'(busy0), 64'h0);
    repeat (2) @(posedge clk); #1;
    check("load_nofetch", 64'(busy0), 64'h0);
    check("load_keep_valid", 64'(ir_valid0), 64'h1);
    fetch0(16'h3478, 8'h01, 3);
    drain("wrap");

    // flush after first beat, coinciding with a ready second beat
    fetch_req0 = 1; @(posedge clk); #1 fetch_req0 = 0;
    @(posedge clk); #1 flush0 = 1;
    @(posedge clk); #1 flush0 = 0;
    check("flush_busy", 64'(busy0), 64'h0);
    check("flush_valid", 64'(ir_valid0), 64'h0);
    check("flush_pc", 64'(pc0), 64'h02);
    check("flush_ir_partial", 64'(ir0), 64'h3412);
    repeat (5) @(posedge clk); #1;

    // flush in IDLE does nothing
    flush0 = 1; @(posedge clk); #1 flush0 = 0;
    check("idle_flush_pc", 64'(pc0), 64'h02);
    check("idle_flush_ir", 64'(ir0), 64'h3412);
    check("idle_flush_busy", 64'(busy0), 64'h0);

    // pc_load / fetch_req during READ are ignored
    wait_n = 2;
    fetch0(16'hABCD, 8'h04, 7);
    pc_load0 = 1; pc_load_val0 = 8'h50; fetch_req0 = 1;
    repeat (3) @(posedge clk);
    #1 pc_load0 = 0; fetch_req0 = 0;
    drain("ignore");
    check("ignore_pc", 64'(pc0), 64'h04);
    check("ignore_idle", 64'(busy0), 64'h0);

    // asynchronous reset in the middle of a waiting READ
    fetch_req0 = 1; @(posedge clk); #1 fetch_req0 = 0;
    @(posedge clk); #1;
    check("pre_reset_cs", 64'(mem_cs0), 64'h1);
    #1 rst = 1;
    #1 check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 rst = 0; wait_n = 0;
    @(posedge clk); #1;
    fetch0(16'h1234, 8'h02, 3);
    drain("after_reset");

    // wide instance: 48-bit instruction, PC advances by 3
    fetch1(48'h3333_2222_1111, 12'h003, 4);
    drain("wide_a");
    fetch1(48'h6666_5555_4444, 12'h006, 4);
    drain("wide_b");
    check("wide_wr", 64'(mem_wr1), 64'h0);
    check("wide_busy", 64'(busy1), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
